// File: rtl/product_accumulator.sv
// product_accumulator: sums COUNT consecutive multiplier products into one result
// and presents it on a registered valid/ready output. Carry-out of the ACC_W-bit
// accumulator is tracked per result and reported alongside the sum.
module product_accumulator #(
    parameter int unsigned COUNT = 4,
    parameter int unsigned ACC_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       prod,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    // count only spans 0..COUNT-1, so COUNT=1 still needs a one-bit counter
    localparam int unsigned CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StHold
    } state_e;

    state_e           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic             ovf_acc;
    logic [ACC_W:0]   sum_next;
    logic             accept;

    // One extra bit captures the carry out of the accumulator
    always_comb begin
        sum_next = {1'b0, acc} + (ACC_W + 1)'(prod);
        in_ready = (state != StHold) && !reset;
        accept   = in_valid && in_ready;
        busy     = (count != '0);
    end

    // Control FSM, accumulator and registered result
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            acc       <= '0;
            count     <= '0;
            ovf_acc   <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                StIdle, StAccum: begin
                    if (accept) begin
                        if (count == LAST) begin
                            out_sum   <= sum_next[ACC_W-1:0];
                            out_ovf   <= ovf_acc | sum_next[ACC_W];
                            out_valid <= 1'b1;
                            acc       <= '0;
                            count     <= '0;
                            ovf_acc   <= 1'b0;
                            state     <= StHold;
                        end else begin
                            acc     <= sum_next[ACC_W-1:0];
                            ovf_acc <= ovf_acc | sum_next[ACC_W];
                            count   <= count + 1'b1;
                            state   <= StAccum;
                        end
                    end
                end
                StHold: begin
                    // Result is held stable until the sink takes it
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
